// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and immediate-format classification
// for the decode/operand-fetch slice.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        case (opc)
            OP_IMM, LOAD, JALR, SYSTEM: imm_fmt = IMM_I;
            STORE:                      imm_fmt = IMM_S;
            BRANCH:                     imm_fmt = IMM_B;
            LUI, AUIPC:                 imm_fmt = IMM_U;
            JAL:                        imm_fmt = IMM_J;
            default:                    imm_fmt = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; OP and unknown opcodes yield zero.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_fmt(instr[6:0]))
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Sign-extend without a zero-width replication when XLEN is 32.
    assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: register-file addressing, EX/MEM/WB forwarding,
// load-use stall and the ID/EX pipeline register.
module id_operand_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    output logic [4:0]      raddr0,
    output logic [4:0]      raddr1,
    input  logic [XLEN-1:0] rdata0,
    input  logic [XLEN-1:0] rdata1,
    input  logic            ex_fwd_we,
    input  logic [4:0]      ex_fwd_rd,
    input  logic            ex_fwd_load,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            mem_fwd_we,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_wen
);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [4:0]      rs   [2];
    logic [XLEN-1:0] rdat [2];
    logic [XLEN-1:0] opv  [2];
    logic [XLEN-1:0] imm;
    logic            uses_rs1, uses_rs2, writes_rd;
    logic            load_use, ex_ready_eff;

    assign opc     = if_instr[6:0];
    assign f3      = if_instr[14:12];
    assign rd      = if_instr[11:7];
    assign raddr0  = if_instr[19:15];
    assign raddr1  = if_instr[24:20];
    assign rs[0]   = raddr0;
    assign rs[1]   = raddr1;
    assign rdat[0] = rdata0;
    assign rdat[1] = rdata1;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    // Youngest producer wins; a load in EX has no data yet and is handled by the stall.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            opv[i] = rdat[i];
            if (rs[i] == 5'd0)
                opv[i] = '0;
            else if (ex_fwd_we && ex_fwd_rd == rs[i] && !ex_fwd_load)
                opv[i] = ex_fwd_data;
            else if (mem_fwd_we && mem_fwd_rd == rs[i])
                opv[i] = mem_fwd_data;
            else if (wb_we && wb_waddr == rs[i])
                opv[i] = wb_wdata;
        end
    end

    always_comb begin
        uses_rs1  = !(opc inside {LUI, AUIPC, JAL});
        uses_rs2  = opc inside {OP, STORE, BRANCH};
        writes_rd = (rd != 5'd0) &&
                    ((opc inside {OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC}) ||
                     (opc == SYSTEM && f3 != 3'b000));
    end

    assign load_use = if_valid && ex_fwd_we && ex_fwd_load && (ex_fwd_rd != 5'd0) &&
                      ((uses_rs1 && rs[0] == ex_fwd_rd) || (uses_rs2 && rs[1] == ex_fwd_rd));

    assign ex_ready_eff = ex_ready || !ex_valid;
    assign id_ready     = ex_ready_eff && !load_use;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_op_a     <= '0;
            ex_op_b     <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_wen      <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!ex_ready_eff) begin
            ex_valid <= ex_valid;
        end else if (load_use) begin
            ex_valid <= 1'b0;
        end else begin
            ex_valid    <= if_valid;
            ex_pc       <= if_pc;
            ex_op_a     <= opv[0];
            ex_op_b     <= opv[1];
            ex_imm      <= imm;
            ex_rd       <= rd;
            ex_opcode   <= opc;
            ex_funct3   <= f3;
            ex_funct7b5 <= if_instr[30];
            ex_wen      <= writes_rd;
        end
    end

endmodule
